// File: rtl/cnn_mem_pkg.sv
// Shared constants, FSM state encodings and word-packing helper for the
// feature-map memory layout (16 FP16 pixels per 256-bit word).
package cnn_mem_pkg;

  localparam int MEM_WORD_WIDTH = 256;
  localparam int PIX_PER_WORD   = 16;
  localparam int FP16_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LO   = 2'd1,
    W_HI   = 2'd2
  } wr_state_e;

  // Keeps the first 'lanes' pixels of the slice and zeroes the rest.
  function automatic logic [MEM_WORD_WIDTH-1:0] pack_word(
    input logic [MEM_WORD_WIDTH-1:0] pixels,
    input int                        lanes
  );
    logic [MEM_WORD_WIDTH-1:0] word;
    word = '0;
    for (int j = 0; j < PIX_PER_WORD; j++) begin
      if (j < lanes) begin
        word[j*FP16_WIDTH +: FP16_WIDTH] = pixels[j*FP16_WIDTH +: FP16_WIDTH];
      end else begin
        word[j*FP16_WIDTH +: FP16_WIDTH] = {FP16_WIDTH{1'b0}};
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/conv_col_writer_fifo.sv
// Small synchronous column FIFO; a push into a full FIFO is accepted when a
// pop happens on the same edge.
module col_fifo #(
  parameter int WIDTH = 389,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign level     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/conv_col_writer.sv
// Write-back of completed convolution output columns into the feature-map
// memory as two packed words per column (address = column*2 + half).
module conv_col_writer
  import cnn_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int COL_BASE    = 1,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 2,
  localparam int OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int CNW        = $clog2(IMAGE_SIZE) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      valid_in_col,
  input  logic [CNW-1:0]            col_num,
  input  logic [DATA_WIDTH-1:0]     col_data [OUT_SIZE-1:0],
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [MEM_WORD_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      err_range
);

  localparam int IDXW     = $clog2(OUT_SIZE);
  localparam int DW_ALL   = OUT_SIZE * DATA_WIDTH;
  localparam int EW       = DW_ALL + IDXW;
  localparam int FLW      = $clog2(FIFO_DEPTH + 1);
  localparam int CCW      = $clog2(OUT_SIZE + 1);
  localparam int HI_LANES = OUT_SIZE - PIX_PER_WORD;
  localparam logic [CNW-1:0] COL_LO   = CNW'(COL_BASE);
  localparam logic [CNW-1:0] COL_HI   = CNW'(COL_BASE + OUT_SIZE);
  localparam logic [CCW-1:0] CNT_LAST = CCW'(OUT_SIZE);

  top_state_e state_r, state_next_s;
  wr_state_e  wstate_r, wstate_next_s;

  logic [CCW-1:0]        col_cnt_r, col_cnt_next_s;
  logic                  overflow_r, err_range_r;
  logic [DW_ALL-1:0]     col_flat_s;
  logic                  in_range_s, push_req_s, push_s, pop_s, clear_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [FLW-1:0]        fifo_level_s;
  logic [EW-1:0]         fifo_head_s;
  logic [IDXW-1:0]       head_idx_s;
  logic [DW_ALL-1:0]     head_data_s;
  logic [ADDR_WIDTH-1:0] col_addr_s;

  // Flatten the column so pixel i sits in bits i*DATA_WIDTH.
  always_comb begin
    col_flat_s = '0;
    for (int i = 0; i < OUT_SIZE; i++) begin
      col_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = col_data[i];
    end
  end

  assign clear_s     = (state_r == IDLE) && start;
  assign in_range_s  = (col_num >= COL_LO) && (col_num < COL_HI);
  assign push_req_s  = (state_r == ACTIVE) && valid_in_col && in_range_s;
  assign pop_s       = (wstate_r == W_HI) && mem_ready;
  assign push_s      = push_req_s && (!fifo_full_s || pop_s);
  assign head_idx_s  = fifo_head_s[EW-1 -: IDXW];
  assign head_data_s = fifo_head_s[DW_ALL-1:0];
  assign col_addr_s  = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(head_idx_s) << 1);

  col_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .push  (push_s),
    .din   ({IDXW'(col_num - COL_LO), col_flat_s}),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s),
    .head  (fifo_head_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wstate_r    <= W_IDLE;
      col_cnt_r   <= '0;
      overflow_r  <= 1'b0;
      err_range_r <= 1'b0;
    end else if (clear_s) begin
      state_r     <= state_next_s;
      wstate_r    <= W_IDLE;
      col_cnt_r   <= '0;
      overflow_r  <= 1'b0;
      err_range_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      wstate_r  <= wstate_next_s;
      col_cnt_r <= col_cnt_next_s;
      if (push_req_s && !push_s) overflow_r <= 1'b1;
      if ((state_r == ACTIVE) && valid_in_col && !in_range_s) err_range_r <= 1'b1;
    end
  end

  // Frame completes on the edge that pops the last column.
  always_comb begin
    col_cnt_next_s = pop_s ? col_cnt_r + CCW'(1) : col_cnt_r;
    state_next_s   = state_r;
    case (state_r)
      IDLE:     state_next_s = start ? ACTIVE : IDLE;
      ACTIVE:   state_next_s = (col_cnt_next_s == CNT_LAST) ? COMPLETE : ACTIVE;
      COMPLETE: state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // W_HI chains straight into W_LO when another column remains after the pop.
  always_comb begin
    wstate_next_s = wstate_r;
    case (wstate_r)
      W_IDLE: wstate_next_s = fifo_empty_s ? W_IDLE : W_LO;
      W_LO:   wstate_next_s = mem_ready ? W_HI : W_LO;
      W_HI: begin
        if (!mem_ready) begin
          wstate_next_s = W_HI;
        end else if ((fifo_level_s > FLW'(1)) || push_s) begin
          wstate_next_s = W_LO;
        end else begin
          wstate_next_s = W_IDLE;
        end
      end
      default: wstate_next_s = W_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_r != IDLE);
    done      = (state_r == COMPLETE);
    overflow  = overflow_r;
    err_range = err_range_r;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (wstate_r)
      W_LO: begin
        mem_we    = 1'b1;
        mem_addr  = col_addr_s;
        mem_wdata = pack_word(head_data_s[MEM_WORD_WIDTH-1:0], PIX_PER_WORD);
      end
      W_HI: begin
        mem_we    = 1'b1;
        mem_addr  = col_addr_s + ADDR_WIDTH'(1);
        mem_wdata = pack_word(MEM_WORD_WIDTH'(head_data_s >> MEM_WORD_WIDTH), HI_LANES);
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_col_writer.sv
// Directed self-checking bench for conv_col_writer: latency, full frame,
// backpressure, full-FIFO push on pop, range errors and mid-frame reset.
module tb_conv_col_writer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         valid_in_col;
  logic [5:0]   col_num;
  logic [15:0]  col_data [23:0];
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         err_range;

  int n_checks;
  int n_errors;
  int wr_cnt;
  int done_cnt;
  logic [11:0]  wr_addr [64];
  logic [255:0] wr_data [64];

  localparam logic [255:0] SINGLE_LO =
    256'h3C0F3C0E_3C0D3C0C_3C0B3C0A_3C093C08_3C073C06_3C053C04_3C033C02_3C013C00;
  localparam logic [255:0] SINGLE_HI =
    256'h00000000_00000000_00000000_00000000_3C173C16_3C153C14_3C133C12_3C113C10;

  conv_col_writer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .valid_in_col (valid_in_col),
    .col_num      (col_num),
    .col_data     (col_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .err_range    (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side log of accepted writes and done pulses.
  always @(negedge clk) begin
    if (mem_we && mem_ready && wr_cnt < 64) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; valid_in_col = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [15:0] col_base(input int c);
    return 16'(c * 256);
  endfunction

  task automatic set_col(input int c, input logic [15:0] base);
    col_num = 6'(c);
    for (int i = 0; i < 24; i++) col_data[i] = base + 16'(i);
  endtask

  // Expected word: half 0 = pixels 0..15, half 1 = pixels 16..23 in lanes 0..7.
  function automatic logic [255:0] exp_word(input logic [15:0] base, input int half);
    logic [255:0] w;
    w = '0;
    if (half == 0) begin
      for (int j = 0; j < 16; j++) w[j*16 +: 16] = base + 16'(j);
    end else begin
      for (int j = 0; j < 8; j++) w[j*16 +: 16] = base + 16'(16 + j);
    end
    return w;
  endfunction

  task automatic send_frame();
    for (int c = 1; c <= 24; c++) begin
      set_col(c, col_base(c));
      valid_in_col = 1'b1;
      tick();
      valid_in_col = 1'b0;
      tick();
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 100) begin
      tick();
      k++;
    end
    check(tag, 256'(done_cnt != 0), 256'(1));
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nwr"}, 256'(wr_cnt), 256'(48));
    for (int k = 0; k < 48 && k < wr_cnt; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 256'(wr_addr[k]), 256'(k));
      check($sformatf("%s_data%0d", tag, k), wr_data[k], exp_word(col_base(k/2 + 1), k % 2));
    end
    check({tag, "_done1"}, 256'(done_cnt), 256'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic hit;
    n_checks = 0; n_errors = 0;
    clear_log();
    rst = 1'b1; start = 1'b0; valid_in_col = 1'b0; col_num = '0; mem_ready = 1'b1;
    for (int i = 0; i < 24; i++) col_data[i] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_we", 256'(mem_we), 256'(0));
    check("rst_addr", 256'(mem_addr), 256'(0));
    check("rst_wdata", mem_wdata, 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_ovf", 256'(overflow), 256'(0));
    check("rst_err", 256'(err_range), 256'(0));

    // Single column, cycle-exact latency
    do_start();
    clear_log();
    set_col(1, 16'h3C00);
    valid_in_col = 1'b1;
    tick();
    valid_in_col = 1'b0;
    @(negedge clk);
    check("s_n0_we", 256'(mem_we), 256'(0));
    tick(); @(negedge clk);
    check("s_lo_we", 256'(mem_we), 256'(1));
    check("s_lo_addr", 256'(mem_addr), 256'(0));
    check("s_lo_data", mem_wdata, SINGLE_LO);
    tick(); @(negedge clk);
    check("s_hi_we", 256'(mem_we), 256'(1));
    check("s_hi_addr", 256'(mem_addr), 256'(1));
    check("s_hi_data", mem_wdata, SINGLE_HI);
    tick(); @(negedge clk);
    check("s_after_we", 256'(mem_we), 256'(0));
    check("s_busy", 256'(busy), 256'(1));
    check("s_nodone", 256'(done_cnt), 256'(0));

    // Full frame
    do_reset();
    do_start();
    clear_log();
    send_frame();
    wait_done("ff_done");
    check_frame("ff");
    check("ff_ovf", 256'(overflow), 256'(0));
    check("ff_err", 256'(err_range), 256'(0));
    check("ff_idle", 256'(busy), 256'(0));

    // Backpressure: three back-to-back columns into a stalled 2-deep FIFO
    do_reset();
    do_start();
    clear_log();
    mem_ready = 1'b0;
    valid_in_col = 1'b1;
    set_col(1, col_base(1)); tick();
    set_col(2, col_base(2)); tick();
    set_col(3, col_base(3)); tick();
    valid_in_col = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check($sformatf("bp_we%0d", s), 256'(mem_we), 256'(1));
      check($sformatf("bp_addr%0d", s), 256'(mem_addr), 256'(0));
      check($sformatf("bp_data%0d", s), mem_wdata, exp_word(col_base(1), 0));
      tick();
    end
    @(negedge clk);
    check("bp_ovf", 256'(overflow), 256'(1));
    mem_ready = 1'b1;
    repeat (10) tick();
    check("bp_nwr", 256'(wr_cnt), 256'(4));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_waddr%0d", k), 256'(wr_addr[k]), 256'(k));
      check($sformatf("bp_wdata%0d", k), wr_data[k], exp_word(col_base(k/2 + 1), k % 2));
    end

    // Push into a full FIFO on the W_HI pop edge
    do_reset();
    do_start();
    clear_log();
    mem_ready = 1'b0;
    valid_in_col = 1'b1;
    set_col(1, col_base(1)); tick();
    set_col(2, col_base(2)); tick();
    valid_in_col = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    set_col(3, col_base(3));
    valid_in_col = 1'b1;
    tick();
    valid_in_col = 1'b0;
    repeat (8) tick();
    check("pp_nwr", 256'(wr_cnt), 256'(6));
    check("pp_addr4", 256'(wr_addr[4]), 256'(4));
    check("pp_data4", wr_data[4], exp_word(col_base(3), 0));
    check("pp_data5", wr_data[5], exp_word(col_base(3), 1));
    check("pp_ovf", 256'(overflow), 256'(0));

    // Out-of-range column numbers
    do_reset();
    do_start();
    clear_log();
    valid_in_col = 1'b1;
    set_col(0, 16'h1111); tick();
    set_col(25, 16'h2222); tick();
    valid_in_col = 1'b0;
    repeat (4) tick();
    check("er_nwr", 256'(wr_cnt), 256'(0));
    check("er_err", 256'(err_range), 256'(1));
    check("er_ovf", 256'(overflow), 256'(0));
    send_frame();
    wait_done("er_done");
    check("er_sticky", 256'(err_range), 256'(1));
    do_start();
    @(negedge clk);
    check("er_cleared", 256'(err_range), 256'(0));
    check("er_busy", 256'(busy), 256'(1));

    // Reset during W_HI of column 5, then a clean frame
    do_reset();
    do_start();
    clear_log();
    hit = 1'b0;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      if ((cyc % 2 == 0) && (cyc / 2 + 1 <= 24)) begin
        set_col(cyc / 2 + 1, col_base(cyc / 2 + 1));
        valid_in_col = 1'b1;
      end else begin
        valid_in_col = 1'b0;
      end
      @(negedge clk);
      if (mem_we && mem_addr == 12'd9) hit = 1'b1;
      else tick();
    end
    check("ab_hit", 256'(hit), 256'(1));
    rst = 1'b1;
    valid_in_col = 1'b0;
    tick();
    @(negedge clk);
    check("ab_we", 256'(mem_we), 256'(0));
    check("ab_addr", 256'(mem_addr), 256'(0));
    check("ab_wdata", mem_wdata, 256'(0));
    check("ab_busy", 256'(busy), 256'(0));
    check("ab_done", 256'(done), 256'(0));
    rst = 1'b0;
    tick();
    do_start();
    clear_log();
    send_frame();
    wait_done("ab_fdone");
    check_frame("ab");
    check("ab_ovf", 256'(overflow), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_col_writer.md
# conv_col_writer

- Write-back end of the FP16 convolution datapath.
- Accepts completed output columns from the convolution engine: one `valid_in_col` pulse carries OUT_SIZE FP16 results plus a column number.
- Buffers them in a small column FIFO and writes each column to the 256-bit feature-map memory as two packed words.
- Uses the same layout the image reader consumes: address = column*2 + half, 16 pixels per word, pixel j in bits j*16 +: 16. The next layer can therefore read the result unchanged.

## Interface
Parameters:
- DATA_WIDTH, 16, FP16 pixel width
- IMAGE_SIZE, 28, input image edge length
- KERNEL_SIZE, 5, convolution kernel edge
- OUT_SIZE (localparam), IMAGE_SIZE-KERNEL_SIZE+1 = 24, results per column
- COL_BASE, 1, col_num value of the first output column
- BASE_ADDR, 0, memory word address of output column 0
- ADDR_WIDTH, 12, memory address width
- FIFO_DEPTH, 2, buffered columns

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  arms a frame; honoured only in IDLE
- valid_in_col  in  1  one-cycle strobe, col_data/col_num valid
- col_num  in  $clog2(IMAGE_SIZE)+1  column index of col_data
- col_data  in  DATA_WIDTH x OUT_SIZE (unpacked [OUT_SIZE-1:0])  column results, index 0 = top row
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  256  packed word
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, frame fully written
- overflow  out  1  sticky, a column was dropped because the FIFO was full
- err_range  out  1  sticky, a column was dropped because col_num was out of range

## Operation
- Top FSM: IDLE -> ACTIVE on start; ACTIVE -> COMPLETE when the written-column counter reaches OUT_SIZE; COMPLETE -> IDLE unconditionally. done = 1 only in COMPLETE.
- start in IDLE clears the FIFO, the column counter, overflow and err_range. start outside IDLE is ignored.
- Push: in ACTIVE, valid_in_col with COL_BASE <= col_num < COL_BASE+OUT_SIZE pushes {col_num-COL_BASE, col_data}. Any other col_num is dropped and sets err_range.
- FIFO full: a push is accepted only if the FIFO is not full, or a pop occurs on the same edge; otherwise the column is dropped and overflow is set.
- valid_in_col outside ACTIVE is ignored and raises no flag.
- Write engine sub-FSM: W_IDLE -> W_LO when the FIFO is non-empty.
  - W_LO: mem_we=1, addr = BASE_ADDR + 2*idx, data = pixels 0..15.
  - W_LO -> W_HI on mem_ready.
  - W_HI: addr = BASE_ADDR + 2*idx + 1, lanes 0..7 = pixels 16..23, lanes 8..15 = 0.
  - W_HI on mem_ready: pop, increment the column counter, then go to W_LO if the FIFO is still non-empty, else W_IDLE.
- Address arithmetic is done in ADDR_WIDTH bits, truncating. No FP arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, err_range=0. FSMs are in IDLE/W_IDLE and the FIFO is empty.
- Reset asserted mid-frame aborts the frame at that edge. No partial write completes after it.
- mem_we, mem_addr and mem_wdata are decoded from registered state and the FIFO head. They hold stable while mem_we=1 and mem_ready=0.
- Latency (mem_ready=1):
  - column captured at edge N;
  - word 0 presented in cycle N+1;
  - word 1 presented in cycle N+2;
  - pop at edge N+3.
- Throughput is one column per 2 cycles, which matches the reader's 2-words-per-column rate.
- done is asserted in the cycle after the edge that accepts the last W_HI word. Columns are written in arrival order; their arrival order is not checked.

## Structure
- Shared package cnn_mem_pkg holds:
  - MEM_WORD_WIDTH=256;
  - PIX_PER_WORD=16;
  - FP16_WIDTH=16;
  - the top-FSM and write-engine state enums;
  - a pack function that takes a pixel slice and returns a 256-bit word with unused lanes zero.
- One sub-module: col_fifo, a FIFO_DEPTH-entry synchronous FIFO.
  - Entry width: OUT_SIZE*DATA_WIDTH + $clog2(OUT_SIZE) bits.
  - Ports: push, pop, full, empty, head.
  - Handles simultaneous push and pop when full.

## Test plan
- Single column: start; col_num=1, pixel i = 16'h3C00+i; mem_ready=1.
  - Cycle N+1: addr 0, lanes 0..15 = 3C00..3C0F.
  - Cycle N+2: addr 1, lanes 0..7 = 3C10..3C17, bits 255:128 = 0.
  - busy stays high; no done.
- Full frame: col_num 1..24 every 2 cycles, mem_ready=1 -> 48 writes at addresses 0..47 in order, a single done pulse, overflow=0, err_range=0.
- Backpressure: mem_ready=0 for 6 cycles during W_LO; 3 columns arrive on consecutive cycles.
  - addr and data are held stable throughout the stall.
  - The third column is dropped and overflow=1.
  - After release, only the first two columns are written.
- Full FIFO with push on the same edge as the W_HI pop -> the push is accepted and overflow stays 0.
- col_num=0 and col_num=25 -> no write and err_range=1; a subsequent start clears it to 0.
- rst asserted during W_HI of column 5 -> all outputs zero next cycle. A new start plus a full frame then completes normally with addresses 0..47.
